alu_result_stage: RTL and testbench

// - Execute-stage output buffer directly downstream of the scalar ALU adder.
// - Accepts {result, N,Z,C,V} through a 2-entry skid buffer (valid/ready) and forwards it to the EX/MEM boundary.
// - Owns the architectural NZCV status register, updated in program order on accepted ops with set_flags.
// - Evaluates 4-bit condition codes against the status register for branch and conditional-execute logic.

---
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage.sv | 139 +++++++++++++
 tb/tb_alu_result_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle for alu_result_stage: ALU input side, EX/MEM output side,
// external NZCV write and condition-code query. master = driver of the stage, slave = the stage.
interface alu_result_stage_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [3:0]   in_flags;
  logic         in_set_flags;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;

  logic         flag_wr_en;
  logic [3:0]   flag_wr_data;

  logic [3:0]   cond;
  logic         cond_pass;
  logic [3:0]   status_flags;

  modport master (
    output in_valid, in_result, in_flags, in_set_flags,
    output out_ready,
    output flag_wr_en, flag_wr_data,
    output cond,
    input  in_ready, out_valid, out_result, out_flags,
    input  cond_pass, status_flags
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_set_flags,
    input  out_ready,
    input  flag_wr_en, flag_wr_data,
    input  cond,
    output in_ready, out_valid, out_result, out_flags,
    output cond_pass, status_flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result buffer (2-entry skid, 1-cycle latency when empty, in_ready registered = count<2) owning NZCV.
// Optional macro FLAG_FORWARD_EN: cond_pass sees the not-yet-registered flag update for zero-cycle branch.
module alu_result_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [N-1:0] result;
    logic [3:0]   flags;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;

  entry_t     head_q;
  entry_t     tail_q;
  entry_t     in_ent;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       in_ready_q;
  logic       push;
  logic       pop;
  logic [3:0] status_q;
  logic [3:0] status_d;
  logic [3:0] cond_flags;

  assign in_ent = '{result: bus.in_result, flags: bus.in_flags};
  assign push   = bus.in_valid & in_ready_q;
  assign pop    = (count_q != 2'd0) & bus.out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Head is a dedicated register so out_* keep the last value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
        head_q <= in_ent;
      end else if (pop && count_q == 2'd2) begin
        head_q <= tail_q;
      end
      if (push && count_q == 2'd1 && !pop) begin
        tail_q <= in_ent;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d < FULL_CNT);
    end
  end

  // External write outranks the in-order flag update from an accepted op.
  always_comb begin
    status_d = status_q;
    if (bus.flag_wr_en) begin
      status_d = bus.flag_wr_data;
    end else if (push && bus.in_set_flags) begin
      status_d = bus.in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
    end else begin
      status_q <= status_d;
    end
  end

`ifdef FLAG_FORWARD_EN
  assign cond_flags = status_d;
`else
  assign cond_flags = status_q;
`endif

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic fn;
    logic fz;
    logic fc;
    logic fv;
    logic r;
    {fn, fz, fc, fv} = f;
    case (cc)
      CC_EQ:   r = fz;
      CC_NE:   r = !fz;
      CC_CS:   r = fc;
      CC_CC:   r = !fc;
      CC_MI:   r = fn;
      CC_PL:   r = !fn;
      CC_VS:   r = fv;
      CC_VC:   r = !fv;
      CC_HI:   r = fc & !fz;
      CC_LS:   r = !fc | fz;
      CC_GE:   r = (fn == fv);
      CC_LT:   r = (fn != fv);
      CC_GT:   r = !fz & (fn == fv);
      CC_LE:   r = fz | (fn != fv);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_result   = head_q.result;
  assign bus.out_flags    = head_q.flags;
  assign bus.status_flags = status_q;
  assign bus.cond_pass    = cond_eval(bus.cond, cond_flags);

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic
// against a queue-based reference model (honours FLAG_FORWARD_EN when defined).
module tb_alu_result_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;

  alu_result_stage_if #(.N(32)) bus ();

  alu_result_stage #(.N(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [35:0] mq[$];
  bit          m_rdy;
  logic [31:0] m_res;
  logic [3:0]  m_flg;
  logic [3:0]  m_status;

`ifdef FLAG_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] m_fwd_flags();
    if (bus.flag_wr_en) return bus.flag_wr_data;
    if (bus.in_valid && m_rdy && bus.in_set_flags) return bus.in_flags;
    return m_status;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_rdy = 1'b1;
    m_res = '0;
    m_flg = '0;
    m_status = 4'b0000;
  endtask

  // One clock edge with the model advanced alongside; returns at edge+1.
  task automatic tick();
    bit push, pop;
    logic [3:0] st_n;
    push = bus.in_valid && m_rdy;
    pop  = (mq.size() != 0) && bus.out_ready;
    st_n = m_fwd_flags();
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({bus.in_result, bus.in_flags});
    m_rdy = (mq.size() < 2);
    if (mq.size() != 0) {m_res, m_flg} = mq[0];
    m_status = st_n;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_result = '0; bus.in_flags = '0; bus.in_set_flags = 0;
    bus.out_ready = 0; bus.flag_wr_en = 0; bus.flag_wr_data = '0; bus.cond = 4'd14;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.status_flags !== 4'b0000) begin n_bad++; $display("FAIL reset_status got=%b exp=0000", bus.status_flags); end
    n_checks++; if ({bus.out_result, bus.out_flags} !== 36'd0) begin n_bad++; $display("FAIL reset_out_data got=%h/%b exp=0/0", bus.out_result, bus.out_flags); end
    bus.cond = 4'd0; #1;
    n_checks++; if (bus.cond_pass !== 1'b0) begin n_bad++; $display("FAIL reset_cond_eq got=%b exp=0", bus.cond_pass); end
    bus.cond = 4'd14; #1;
    n_checks++; if (bus.cond_pass !== 1'b1) begin n_bad++; $display("FAIL reset_cond_al got=%b exp=1", bus.cond_pass); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_op();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_result = 32'h0000_0002;
    bus.in_flags = 4'b0010; bus.in_set_flags = 1;
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_result !== 32'h2) begin n_bad++; $display("FAIL single_out_result got=%h exp=2", bus.out_result); end
    n_checks++; if (bus.status_flags !== 4'b0010) begin n_bad++; $display("FAIL single_status got=%b exp=0010", bus.status_flags); end
    bus.cond = 4'd2; #1;
    n_checks++; if (bus.cond_pass !== 1'b1) begin n_bad++; $display("FAIL single_cond_cs got=%b exp=1", bus.cond_pass); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_result !== 32'h2) begin n_bad++; $display("FAIL single_hold got=%h exp=2", bus.out_result); end
  endtask

  task automatic test_backpressure();
    logic [31:0] va, vb, vc;
    va = $urandom; vb = $urandom; vc = $urandom;
    bus.out_ready = 0; bus.in_set_flags = 0; bus.in_flags = 4'b0001;
    bus.in_valid = 1; bus.in_result = va; tick();
    bus.in_result = vb; tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready); end
    bus.in_result = vc; tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_held_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_result !== va) begin n_bad++; $display("FAIL bp_head_stable got=%h exp=%h", bus.out_result, va); end
    bus.out_ready = 1; tick();
    n_checks++; if (bus.out_result !== vb) begin n_bad++; $display("FAIL bp_drain_b got=%h exp=%h", bus.out_result, vb); end
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_result !== vc || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_c got=%h/%b exp=%h/1", bus.out_result, bus.out_valid, vc); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_flag_priority();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_result = 32'h11;
    bus.in_flags = 4'b0100; bus.in_set_flags = 1;
    bus.flag_wr_en = 1; bus.flag_wr_data = 4'b1001;
    tick();
    bus.flag_wr_en = 0;
    n_checks++; if (bus.status_flags !== 4'b1001) begin n_bad++; $display("FAIL prio_wr_wins got=%b exp=1001", bus.status_flags); end
    bus.in_flags = 4'b0110; bus.in_set_flags = 0;
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.status_flags !== 4'b1001) begin n_bad++; $display("FAIL prio_no_set got=%b exp=1001", bus.status_flags); end
    tick(); tick();
  endtask

  task automatic test_forwarding();
    bus.flag_wr_en = 1; bus.flag_wr_data = 4'b0000;
    tick();
    bus.flag_wr_en = 0;
    bus.in_valid = 1; bus.in_result = 32'h5; bus.in_flags = 4'b0100; bus.in_set_flags = 1;
    bus.cond = 4'd0; #1;
    n_checks++; if (bus.cond_pass !== FWD) begin n_bad++; $display("FAIL fwd_same_cycle got=%b exp=%b", bus.cond_pass, FWD); end
    tick();
    bus.in_valid = 0; #1;
    n_checks++; if (bus.cond_pass !== 1'b1) begin n_bad++; $display("FAIL fwd_next_cycle got=%b exp=1", bus.cond_pass); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.in_result    = $urandom;
      bus.in_flags     = 4'($urandom);
      bus.in_set_flags = $urandom_range(0, 1);
      bus.out_ready    = ($urandom_range(0, 2) != 0);
      bus.flag_wr_en   = ($urandom_range(0, 7) == 0);
      bus.flag_wr_data = 4'($urandom);
      bus.cond         = 4'($urandom);
      #1;
      n_checks++;
      if (bus.cond_pass !== m_cond(bus.cond, FWD ? m_fwd_flags() : m_status)) begin
        n_bad++; $display("FAIL rnd_cond i=%0d cond=%0d got=%b exp=%b", i, bus.cond, bus.cond_pass,
                          m_cond(bus.cond, FWD ? m_fwd_flags() : m_status));
      end
      tick();
      n_checks++;
      if (bus.out_valid !== (mq.size() != 0) || bus.in_ready !== m_rdy ||
          bus.out_result !== m_res || bus.out_flags !== m_flg || bus.status_flags !== m_status) begin
        n_bad++;
        $display("FAIL rnd_state i=%0d got v=%b r=%b d=%h f=%b s=%b exp v=%b r=%b d=%h f=%b s=%b", i,
                 bus.out_valid, bus.in_ready, bus.out_result, bus.out_flags, bus.status_flags,
                 (mq.size() != 0), m_rdy, m_res, m_flg, m_status);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [31:0] vn;
    bus.out_ready = 0; bus.in_valid = 1; bus.in_set_flags = 1; bus.in_flags = 4'b1000;
    bus.in_result = 32'hAAAA_0001; tick();
    bus.in_result = 32'hAAAA_0002; tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL arst_prefill got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.status_flags !== 4'b0000) begin n_bad++; $display("FAIL arst_ready_status got=%b/%b exp=1/0000", bus.in_ready, bus.status_flags); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vn = $urandom;
    bus.in_valid = 1; bus.in_result = vn; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== vn) begin n_bad++; $display("FAIL arst_first_push got=%b/%h exp=1/%h", bus.out_valid, bus.out_result, vn); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_bad = 0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_flag_priority();
    test_forwarding();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
